fetch_decode_buf: RTL
=====================

Name: fetch_decode_buf

Overview:
Elastic IF/ID boundary between the fetch stage and the decode stage of the 16-bit pipelined core.
- Accepts {instr, PC2} beats from fetch through a valid/ready handshake.
- Holds them in a small FIFO and presents them to decode.
- Inserts NOPs when empty and drops contents on a branch/jump flush.
- Latches HALT so fetch stops issuing after a halt instruction has been accepted.

Parameters:
- DEPTH, 2: FIFO entries; power of two, at least 2.
- NOP_INSTR, 16'h0800: encoding driven on out_instr when out_valid = 0.
- HALT_OPC, 5'b00000: opcode (instr[15:11]) that marks a halt.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a beat.
- in_instr  in  16  fetched instruction.
- in_pc2  in  16  PC+2 of that instruction.
- in_ready  out  1  buffer can accept a beat this cycle.
- out_valid  out  1  decode-side beat valid.
- out_instr  out  16  instruction to decode; NOP_INSTR when out_valid = 0.
- out_pc2  out  16  PC+2 to decode; 16'h0000 when out_valid = 0.
- out_ready  in  1  decode consumes the beat (deasserted on a decode stall).
- flush  in  1  redirect from execute; discard all buffered beats.
- halt_seen  out  1  sticky; a HALT beat has been accepted.
- err  out  1  sticky handshake-protocol violation flag.

Behaviour:
- Reset state (rst high at a clock edge):
  - count = 0; read and write pointers = 0.
  - halt_seen = 0, err = 0.
  - out_valid = 0, out_instr = NOP_INSTR, out_pc2 = 0.
  - in_ready = 0 during the reset cycle, 1 in the first cycle after reset.
  - Reset mid-operation discards all entries. No beat is delivered after reset until a new push.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH) && !halt_seen. It is a combinational function of registered state only; it never depends on in_valid.
- Latency:
  - A pushed beat appears on out_* in the next cycle, at the earliest.
  - Output is the head entry, in strict FIFO order.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. This is legal at any count below DEPTH.
  - At count = DEPTH, in_ready = 0, so a push cannot occur.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Flush (highest priority after rst):
  - Next cycle: count = 0 and the pointers are equal.
  - A push or pop in the flush cycle is ignored; the incoming beat is dropped.
  - out_valid = 0 in the cycle after flush.
  - halt_seen is not cleared by flush.
- Halt:
  - On a push with in_instr[15:11] == HALT_OPC, halt_seen sets the next cycle.
  - The HALT beat is still delivered to decode.
  - From the next cycle in_ready = 0 until rst.
  - Flush and HALT in the same cycle: the beat is dropped and halt_seen does not set.
- Error:
  - err sets when, in cycle N, in_valid = 1 and in_ready = 0, and in cycle N+1 (with no flush and no rst in N+1) either:
    - in_valid = 0, or
    - in_instr or in_pc2 differs from cycle N.
  - err is sticky until rst.
- Arithmetic: count is log2(DEPTH)+1 bits wide. No arithmetic is performed on PC2; it is carried through unchanged.

Optional Feature:
FDB_BYPASS_EN
- Defined: when count = 0, in_valid && in_ready && out_ready && !flush, the incoming beat goes combinationally to out_* with out_valid = 1 in the same cycle.
  - The beat is consumed without being written.
  - Zero-latency path.
- Not defined: no combinational path from in_* to out_*; minimum latency is 1 cycle.
- The halt and err rules are identical in both builds.

Decomposition:
- Shared package holds:
  - Constants: NOP_INSTR, HALT_OPC, and the instr[15:11] opcode field position.
  - Struct type if_id_beat_t = {instr[15:0], pc2[15:0]}. The execute/decode buffers reuse it.
- One sub-module: fdb_fifo_core.
  - Contents: storage array, wrap-around pointers, count.
  - Interface: push, pop, clear inputs; head, full, empty outputs.
  - The top level adds the handshake, halt, err and NOP-insertion logic.

Test Plan:
1. rst for 2 cycles, then idle → out_valid = 0, out_instr = 16'h0800, out_pc2 = 0, in_ready = 1, halt_seen = 0, err = 0.
2. Push beats {16'h4123, 16'h0002}, {16'h4456, 16'h0004}, {16'h4789, 16'h0006} back-to-back with out_ready = 0, then release → 3rd beat held (in_ready = 0 after 2 pushes). Output order is 4123, 4456, 4789 with PC2 = 2, 4, 6.
3. Fill 2 entries, assert flush for one cycle together with in_valid = 1 and in_instr = 16'hA000 → next cycle out_valid = 0, count = 0, 16'hA000 never appears at the output.
4. Push 16'h0000 (HALT) with PC2 = 16'h0010 → halt_seen = 1 next cycle, in_ready = 0 from then on. HALT is delivered with out_pc2 = 16'h0010. Further in_valid beats are ignored.
5. Hold a beat at full with in_valid = 1, then change in_instr while still not accepted → err = 1 next cycle and stays 1 until rst.
6. FDB_BYPASS_EN defined, empty, out_ready = 1, push 16'h5555 → out_valid = 1 and out_instr = 16'h5555 in the same cycle, count stays 0. Not defined → the beat appears one cycle later.

Source files
------------

// File: rtl/fetch_decode_buf_pkg.sv
// fetch_decode_buf_pkg
// Shared definitions for the IF/ID boundary of the 16-bit core.
// - NOP_INSTR / HALT_OPC : default encodings used by the fetch/decode buffers
// - OPC_MSB / OPC_LSB    : opcode field position inside an instruction
// - if_id_beat_t         : one fetch beat {instr, pc2}, reused by later buffers
// - opc_of()             : extracts the opcode field of an instruction
package fetch_decode_buf_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;
    localparam int          OPC_MSB   = 15;
    localparam int          OPC_LSB   = 11;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } if_id_beat_t;

    function automatic logic [4:0] opc_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_decode_buf_fifo_core.sv
// fdb_fifo_core
// Storage for the IF/ID buffer: a DEPTH-entry ring with wrap-around read and
// write pointers and an occupancy count. It trusts its caller: push is never
// raised when full, pop never when empty. clear empties the ring and wins
// over push/pop.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, pop       enqueue wdata / dequeue head this cycle
//   clear           discard every entry (pointers and count return to zero)
//   wdata           beat to enqueue
//   head            oldest stored beat (meaningless when empty)
//   full, empty     occupancy flags
module fdb_fifo_core
    import fetch_decode_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  if_id_beat_t wdata,
    output if_id_beat_t head,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if_id_beat_t     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_decode_buf.sv
// fetch_decode_buf
// Elastic IF/ID boundary. Fetch beats {instr, pc2} are queued in a small FIFO
// and presented to decode in order; a NOP is shown whenever nothing is valid.
// flush discards everything buffered plus the beat offered that cycle. A
// HALT beat is still delivered but latches halt_seen, which closes in_ready
// until reset. err latches when fetch withdraws or alters a stalled beat.
// Build option: define FDB_BYPASS_EN to let a beat arriving at an empty
// buffer with decode ready pass straight through in the same cycle.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_instr/in_pc2      beat from fetch
//   in_ready                      buffer can take a beat this cycle
//   out_valid/out_instr/out_pc2   beat to decode (NOP_INSTR / 0 when idle)
//   out_ready                     decode consumes the beat
//   flush                         redirect: drop all buffered beats
//   halt_seen                     sticky, a HALT beat was accepted
//   err                           sticky, fetch broke the handshake
//
// Handshake: a beat transfers on a side when its valid and ready are both high
// at a rising edge (in: in_valid && in_ready, out: out_valid && out_ready).
// in_ready never depends on in_valid. Once in_valid is raised it must stay
// high with stable data until accepted, unless flush or rst intervenes.
module fetch_decode_buf #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = fetch_decode_buf_pkg::NOP_INSTR,
    parameter logic [4:0]  HALT_OPC  = fetch_decode_buf_pkg::HALT_OPC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc2,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc2,
    input  logic        out_ready,
    input  logic        flush,
    output logic        halt_seen,
    output logic        err
);
    import fetch_decode_buf_pkg::*;

    if_id_beat_t in_beat, head, blk_beat_q;
    logic        full, empty;
    logic        in_fire, bypass, push, pop;
    logic        halt_seen_q, halt_seen_d;
    logic        err_q, err_d;
    logic        blk_q, blk_d;

    assign in_beat  = '{instr: in_instr, pc2: in_pc2};

    // rst gates in_ready so fetch sees "not ready" during the reset cycle,
    // whatever the pre-reset state was.
    assign in_ready = !rst && !full && !halt_seen_q;

    // A beat offered during flush is accepted by the handshake but discarded.
    assign in_fire  = in_valid && in_ready && !flush;

`ifdef FDB_BYPASS_EN
    assign bypass = empty && in_fire && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat is consumed directly and never occupies an entry.
    assign push = in_fire && !bypass;
    assign pop  = !empty && out_ready && !flush;

    fdb_fifo_core #(
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (in_beat),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        out_valid = 1'b0;
        out_instr = NOP_INSTR;
        out_pc2   = 16'h0000;
        if (bypass) begin
            out_valid = 1'b1;
            out_instr = in_instr;
            out_pc2   = in_pc2;
        end else if (!empty) begin
            out_valid = 1'b1;
            out_instr = head.instr;
            out_pc2   = head.pc2;
        end
    end

    always_comb begin
        halt_seen_d = halt_seen_q;
        err_d       = err_q;
        blk_d       = in_valid && !in_ready;
        if (in_fire && (opc_of(in_instr) == HALT_OPC)) halt_seen_d = 1'b1;
        // Last cycle's beat stalled; it must still be offered unchanged now.
        if (blk_q && !flush && (!in_valid || (in_beat != blk_beat_q))) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        blk_beat_q <= in_beat;
        if (rst) begin
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
            blk_q       <= 1'b0;
        end else begin
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
            blk_q       <= blk_d;
        end
    end

    assign halt_seen = halt_seen_q;
    assign err       = err_q;

endmodule
